// File: rtl/fp4_pkg.sv
// Shared types and lane constants for the 4-lane FP4 (E2M1) MAC array and its sequencer.
package fp4_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} fp4_state_e;

  localparam int LANES  = 4;
  localparam int LANE_W = 4;
  localparam int VEC_W  = LANES * LANE_W;
  localparam logic [LANE_W-1:0] FP4_ZERO = 4'b0000;

  // All-lanes FP4 zero; a zero product leaves the array accumulators untouched.
  function automatic logic [VEC_W-1:0] fp4_vec_zero();
    return {LANES{FP4_ZERO}};
  endfunction
endpackage

// File: rtl/fp4_mac_lat_cnt.sv
// Loadable down-counter with zero flag; times both the clear window and the array drain.
module fp4_mac_lat_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/fp4_mac_seq.sv
// Job sequencer for the 4-lane FP4 MAC array: clear, feed operand beats, drain, hand off result.
module fp4_mac_seq
  import fp4_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int LAT     = 4,
  parameter int CLR_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [VEC_W-1:0] cfg_bias,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [VEC_W-1:0] op_a,
  input  logic [VEC_W-1:0] op_b,
  output logic [VEC_W-1:0] mac_a,
  output logic [VEC_W-1:0] mac_b,
  output logic [VEC_W-1:0] mac_c,
  output logic             mac_clr,
  input  logic [VEC_W-1:0] mac_res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [VEC_W-1:0] res_data,
  output logic             busy
);
  localparam int CNT_W = $clog2(LAT + CLR_CYC + 1) + 1;

  fp4_state_e       state, state_nxt;
  logic [LEN_W-1:0] len_q, beat_cnt;
  logic [VEC_W-1:0] bias_q;
  logic             cnt_load, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             xfer, last_beat, len_zero, clear_to_drain;

  assign cfg_ready = (state == IDLE);
  assign op_ready  = (state == FEED);
  assign mac_clr   = (state == CLEAR);
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign xfer           = op_valid && op_ready;
  assign len_zero       = (len_q == '0);
  assign last_beat      = xfer && (beat_cnt == len_q - LEN_W'(1));
  assign clear_to_drain = (state == CLEAR) && cnt_zero && len_zero;

  fp4_mac_lat_cnt #(.CNT_W(CNT_W)) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    unique case (state)
      IDLE: if (cfg_valid) begin
        state_nxt = CLEAR;
        cnt_load  = 1'b1;
        cnt_val   = CNT_W'(CLR_CYC - 1);
      end
      CLEAR: if (cnt_zero) begin
        state_nxt = len_zero ? DRAIN : FEED;
        cnt_load  = len_zero;
        cnt_val   = CNT_W'(LAT);
      end
      FEED: if (last_beat) begin
        state_nxt = DRAIN;
        cnt_load  = 1'b1;
        cnt_val   = CNT_W'(LAT);
      end
      DRAIN: if (cnt_zero) state_nxt = DONE;
      DONE:  if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Job descriptor and beat count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= '0;
      bias_q   <= '0;
      beat_cnt <= '0;
    end else if (state == IDLE && cfg_valid) begin
      len_q    <= cfg_len;
      bias_q   <= cfg_bias;
      beat_cnt <= '0;
    end else if (xfer) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // Array drive stage; bias rides only with the final beat (or the first drain cycle of an empty job)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_a    <= '0;
      mac_b    <= '0;
      mac_c    <= '0;
      res_data <= '0;
    end else begin
      mac_a <= xfer ? op_a : fp4_vec_zero();
      mac_b <= xfer ? op_b : fp4_vec_zero();
      mac_c <= (last_beat || clear_to_drain) ? bias_q : fp4_vec_zero();
      if (state == DRAIN && cnt_zero)
        res_data <= mac_res;
    end
  end
endmodule

// File: tb/tb_fp4_mac_seq.sv
// Randomized directed bench for fp4_mac_seq against a cycle-timeline reference model.
module tb_fp4_mac_seq;
  localparam int LEN_W   = 8;
  localparam int LAT     = 4;
  localparam int CLR_CYC = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid, cfg_ready;
  logic [LEN_W-1:0] cfg_len;
  logic [15:0]      cfg_bias;
  logic             op_valid, op_ready;
  logic [15:0]      op_a, op_b;
  logic [15:0]      mac_a, mac_b, mac_c;
  logic             mac_clr;
  logic [15:0]      mac_res;
  logic             res_valid, res_ready;
  logic [15:0]      res_data;
  logic             busy;

  int checks = 0;
  int errors = 0;
  logic [15:0] hist [0:2047];
  logic [15:0] last_res = 16'h0000;

  always #5 clk = ~clk;

  fp4_mac_seq #(.LEN_W(LEN_W), .LAT(LAT), .CLR_CYC(CLR_CYC)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_len(cfg_len), .cfg_bias(cfg_bias),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_clr(mac_clr), .mac_res(mac_res),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1({tag, "_cfg_ready"}, cfg_ready, 1'b1);
    chk1({tag, "_op_ready"}, op_ready, 1'b0);
    chk16({tag, "_mac_a"}, mac_a, 16'h0);
    chk16({tag, "_mac_b"}, mac_b, 16'h0);
    chk16({tag, "_mac_c"}, mac_c, 16'h0);
    chk1({tag, "_mac_clr"}, mac_clr, 1'b0);
    chk1({tag, "_res_valid"}, res_valid, 1'b0);
    chk16({tag, "_res_data"}, res_data, 16'h0);
    chk1({tag, "_busy"}, busy, 1'b0);
  endtask

  // vmode: 0 op_valid always high, 1 toggling, 2 random. bp: DONE cycles with res_ready low.
  // abort_at >= 0: assert rst right after that many beats have transferred.
  task automatic run_job(input int len, input logic [15:0] bias, input int vmode,
                         input int bp, input int abort_at);
    int k, xfers, t_last, t_done;
    logic [15:0] a_prev, b_prev, oa, ob;
    bit xfer_prev, last_prev, hs, finished, exp_rdy, in_done;
    a_prev = '0; b_prev = '0; xfer_prev = 0; last_prev = 0; hs = 0; finished = 0;
    xfers = 0;
    t_last = (len == 0) ? CLR_CYC : -1;

    @(negedge clk);
    chk1("idle_cfg_ready", cfg_ready, 1'b1);
    chk1("idle_busy", busy, 1'b0);
    cfg_valid = 1'b1; cfg_len = LEN_W'(len); cfg_bias = bias;
    op_valid = 1'b0; res_ready = 1'b0;
    mac_res = 16'($urandom); hist[0] = mac_res;

    k = 1;
    while (!finished && k < 2000) begin
      @(negedge clk);
      if (hs) begin
        chk1("post_hs_cfg_ready", cfg_ready, 1'b1);
        chk1("post_hs_res_valid", res_valid, 1'b0);
        chk1("post_hs_busy", busy, 1'b0);
        chk16("post_hs_res_data", res_data, last_res);
        cfg_valid = 1'b0; res_ready = 1'b0; op_valid = 1'b0;
        finished = 1;
      end else begin
        t_done  = (t_last >= 0) ? t_last + LAT + 2 : -1;
        in_done = (t_done >= 0) && (k >= t_done);
        exp_rdy = (k > CLR_CYC) && (xfers < len);
        chk1("mac_clr", mac_clr, k <= CLR_CYC);
        chk1("op_ready", op_ready, exp_rdy);
        chk16("mac_a", mac_a, xfer_prev ? a_prev : 16'h0);
        chk16("mac_b", mac_b, xfer_prev ? b_prev : 16'h0);
        chk16("mac_c", mac_c, (last_prev || (len == 0 && k == CLR_CYC + 1)) ? bias : 16'h0);
        chk1("res_valid", res_valid, in_done);
        chk1("cfg_ready_busy", cfg_ready, 1'b0);
        chk1("busy", busy, 1'b1);
        if (in_done) begin
          last_res = hist[t_last + LAT + 1];
          chk16("res_data", res_data, last_res);
        end

        mac_res = 16'($urandom); hist[k] = mac_res;
        cfg_valid = 1'($urandom_range(0, 1));
        cfg_len = LEN_W'($urandom); cfg_bias = 16'($urandom);
        oa = 16'($urandom); ob = 16'($urandom);
        op_a = oa; op_b = ob;
        op_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'(k % 2 == 1) : 1'($urandom_range(0, 1));
        if (in_done) res_ready = 1'((k - t_done) >= bp);
        else         res_ready = 1'($urandom_range(0, 1));
        hs = in_done && res_ready;

        xfer_prev = op_valid && exp_rdy;
        last_prev = 0;
        if (xfer_prev) begin
          a_prev = oa; b_prev = ob; xfers++;
          if (xfers == len) begin last_prev = 1; t_last = k; end
        end

        if (abort_at >= 0 && xfer_prev && xfers == abort_at) begin
          @(posedge clk);
          #2;
          rst = 1'b1;
          #1;
          chk_reset_vals("abort");
          cfg_valid = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
          @(negedge clk);
          chk_reset_vals("abort_held");
          rst = 1'b0;
          finished = 1;
        end
      end
      k++;
    end
    checks++;
    assert (finished) else begin
      errors++;
      $error("FAIL job_timeout observed %0d cycles expected completion", k);
    end
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_len = '0; cfg_bias = '0;
    op_valid = 1'b0; op_a = '0; op_b = '0; mac_res = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    run_job(4, 16'hBEEF, 0, 0, -1);
    run_job(4, 16'h5A5A, 1, 0, -1);
    run_job(0, 16'h1234, 0, 0, -1);
    run_job(4, 16'hC0DE, 0, 10, -1);
    run_job(4, 16'h7777, 0, 0, 2);
    run_job(3, 16'h0F0F, 0, 0, -1);
    run_job(255, 16'hFACE, 0, 0, -1);
    for (int j = 0; j < 12; j++)
      run_job($urandom_range(0, 20), 16'($urandom), 2, $urandom_range(0, 5), -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp4_mac_seq.md
Name: fp4_mac_seq

Overview:
Job sequencer for the 4-lane FP4 (E2M1) multiply-accumulate array.
- Accepts a job descriptor (beat count plus per-lane bias), then clears the lane accumulators.
- Streams operand beats into the array under valid/ready and waits out the array pipeline latency.
- Captures the four packed lane results and holds them on a result handshake until accepted.
- Sits between the operand-fetch logic and the MAC array; owns all array sequencing.

Parameters:
LEN_W, 8, width of job beat count (max 2^LEN_W-1 beats)
LAT, 4, cycles from last operand beat driven to mac_res stable
CLR_CYC, 2, cycles mac_clr is held before first beat

Ports:
clk  in  1  clock
rst  in  1  reset
cfg_valid  in  1  job descriptor valid
cfg_ready  out  1  sequencer can accept descriptor
cfg_len  in  LEN_W  operand beats in job
cfg_bias  in  16  four packed FP4 lane biases, lane0 in [3:0]
op_valid  in  1  operand beat valid
op_ready  out  1  operand beat accepted this cycle
op_a  in  16  four packed FP4 a operands
op_b  in  16  four packed FP4 b operands
mac_a  out  16  to array a inputs
mac_b  out  16  to array b inputs
mac_c  out  16  to array c inputs
mac_clr  out  1  synchronous accumulator clear to array
mac_res  in  16  four packed FP4 array outputs
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
res_data  out  16  captured lane results
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - State IDLE; all counters 0.
  - cfg_ready=1, op_ready=0, mac_a/mac_b/mac_c=0, mac_clr=0, res_valid=0, res_data=0, busy=0.
- Reset mid-job aborts immediately to IDLE; a partially fed job is discarded and no result is produced.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid: latch cfg_len and cfg_bias, go to CLEAR.
- CLEAR:
  - mac_clr=1 for exactly CLR_CYC cycles, with mac_a/mac_b/mac_c=0.
  - Then go to FEED, or to DRAIN if the latched len==0.
- FEED:
  - op_ready=1.
  - A beat transfers when op_valid and op_ready are both 1. Registered mac_a/mac_b take op_a/op_b the next cycle.
  - Cycles with no transfer drive mac_a=mac_b=0. FP4 zero products leave the accumulators unchanged, so bubbles are legal.
  - mac_c=cfg_bias only on the cycle carrying the final beat; 0 otherwise. The bias is therefore added exactly once.
  - Beat counter increments per transfer. On the transfer with count==len-1, op_ready drops the next cycle and the state goes to DRAIN.
- DRAIN:
  - mac_* = 0; down-counter loaded with LAT.
  - For len==0, mac_c=cfg_bias on the first DRAIN cycle.
  - At counter==0: res_data<=mac_res, go to DONE.
- DONE:
  - res_valid=1; res_data stays stable until res_valid and res_ready are both 1.
  - On that handshake, go to IDLE with cfg_ready=1 the next cycle. No back-to-back bypass in this revision.
- cfg_ready=0 outside IDLE; cfg_valid pulses outside IDLE are ignored and must be held by the producer.
- Fixed-count latency: len=N with op_valid always high gives res_valid at cycle 1+CLR_CYC+N+LAT+1 after cfg accept.
- The beat counter never wraps: len is at most 2^LEN_W-1 and the counter is LEN_W bits wide, with the terminal compare on len-1.
- Simultaneous res_ready and a new cfg_valid in DONE: only the result handshake completes; the cfg is taken in IDLE one cycle later.

Decomposition:
- Shared package fp4_pkg:
  - state enum {IDLE, CLEAR, FEED, DRAIN, DONE}
  - FP4_ZERO=4'b0000, LANES=4, LANE_W=4
  - packing helper widths LANES*LANE_W
- Sub-module fp4_mac_lat_cnt: loadable down-counter with zero flag, reused for the CLEAR and DRAIN timing. Everything else stays in fp4_mac_seq.

Test Plan:
- Bench stub array returns mac_res=16'hA5C3 after LAT.
  - Stimulus: cfg_len=4, op_valid constant, op_a=op_b=16'h2222 (1.0 per lane), res_ready=1.
  - Required: mac_clr high 2 cycles; exactly 4 op_ready transfers; mac_c=cfg_bias only on beat 4; res_valid 1+2+4+4+1 cycles after cfg accept; res_data=16'hA5C3.
- Bubbles: same job with op_valid toggling 1,0,1,0,...
  - Required: mac_a=0 on bubble cycles; DRAIN entered only after the 4th transfer; result count still 4.
- Zero-length: cfg_len=0, cfg_bias=16'h1234.
  - Required: no op_ready; mac_c=16'h1234 for one cycle; res_valid after CLR_CYC+LAT+2 cycles.
- Backpressure: res_ready=0 for 10 cycles in DONE while mac_res changes.
  - Required: res_data and res_valid stable; cfg_ready=0; new cfg_valid ignored until the cycle after the handshake.
- Reset mid-FEED: assert rst after beat 2 of 4.
  - Required: outputs return immediately to reset values; no res_valid; the next job runs normally from IDLE.
- Max length: cfg_len=255.
  - Required: exactly 255 transfers, no counter wrap, correct DRAIN entry.
